// File: rtl/multiplicador_pkg.sv
// multiplicador_pkg: shared FSM states and result-width helper for multiplicador_seq
package multiplicador_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int calc_w(input int bit_w, input int m);
    return 2 * bit_w + $clog2(m);
  endfunction
endpackage

// File: rtl/multiplicador_seq_if.sv
// multiplicador_seq_if: operand/result handshake bundle for multiplicador_seq
interface multiplicador_seq_if import multiplicador_pkg::*; #(
  parameter int Bit = 3,
  parameter int M = 4,
  parameter int N = 2
);
  localparam int W = calc_w(Bit, M);
  logic in_valid;
  logic in_ready;
  logic [N*M*Bit-1:0] in1;
  logic [M*Bit-1:0] in2;
  logic out_valid;
  logic out_ready;
  logic [N*W-1:0] out;
  modport master(output in_valid, in1, in2, out_ready, input in_ready, out_valid, out);
  modport slave(input in_valid, in1, in2, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/multiplicador_seq_fila_mac.sv
// fila_mac: combinational M-element dot product; signed when MULTIPLICADOR_SIGNED_EN is defined
module fila_mac #(
  parameter int Bit = 3,
  parameter int M = 4,
  parameter int W = 8
) (
  input  logic [M*Bit-1:0] a,
  input  logic [M*Bit-1:0] x,
  output logic [W-1:0]     y
);
`ifdef MULTIPLICADOR_SIGNED_EN
  typedef logic signed [Bit-1:0] e_t;
  typedef logic signed [W-1:0] w_t;
`else
  typedef logic [Bit-1:0] e_t;
  typedef logic [W-1:0] w_t;
`endif
  w_t acc, ae, xe;
  // widen each element to W first so products and the sum never wrap
  always_comb begin
    acc = '0;
    ae = '0;
    xe = '0;
    for (int k = 0; k < M; k++) begin
      ae = w_t'(e_t'(a[k*Bit +: Bit]));
      xe = w_t'(e_t'(x[k*Bit +: Bit]));
      acc = acc + ae * xe;
    end
  end
  assign y = acc;
endmodule

// File: rtl/multiplicador_seq.sv
// multiplicador_seq: sequential matrix-vector product y = A*x, one row per cycle; MULTIPLICADOR_SIGNED_EN selects signed arithmetic
module multiplicador_seq import multiplicador_pkg::*; #(
  parameter int Bit = 3,
  parameter int M = 4,
  parameter int N = 2
) (
  input logic clk,
  input logic rst,
  multiplicador_seq_if.slave bus
);
  localparam int W = calc_w(Bit, M);
  localparam int RW = N > 1 ? $clog2(N) : 1;
  state_t state, state_nxt;
  logic [RW-1:0] r;
  logic last;
  logic [N*M*Bit-1:0] a_q;
  logic [M*Bit-1:0] x_q;
  logic [N*W-1:0] y_q;
  logic [W-1:0] dot;
  assign last = r == RW'(N - 1);
  assign bus.out = y_q;
  fila_mac #(.Bit(Bit), .M(M), .W(W)) u_mac (
    .a(a_q[r*M*Bit +: M*Bit]),
    .x(x_q),
    .y(dot)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    state_nxt = state == IDLE ? (bus.in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (bus.out_ready ? IDLE : DONE);
  end
  // operand capture on acceptance, one result row written per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      a_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      a_q <= bus.in1;
      x_q <= bus.in2;
      r <= '0;
    end else if (state == BUSY) begin
      y_q[r*W +: W] <= dot;
      r <= last ? '0 : r + 1'b1;
    end
  end
endmodule
